pairhmm_compute_engine_front: RTL and testbench



---
 rtl/pairhmm_compute_engine_front_pkg.sv | 26 ++
 rtl/pairhmm_compute_engine_front_if.sv | 22 ++
 rtl/pairhmm_result_fifo.sv | 61 ++++++
 rtl/pairhmm_compute_engine_front.sv | 131 +++++++++++++
 tb/tb_pairhmm_compute_engine_front.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pairhmm_compute_engine_front_pkg.sv
// PairHMM shared types: worker request/result payloads plus compute-engine front constants.
// Pure declarations; no latency or backpressure of its own.
package PairHMMPackage;

    localparam int CE_FIFO_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic [7:0]  tag;
        logic [11:0] read_len;
        logic [11:0] hap_len;
    } request_t;

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] log_likelihood;
    } result_t;

    // First error cause seen since reset, for debug visibility
    typedef enum logic [1:0] {
        CE_ERR_NONE,
        CE_ERR_REQ_NOT_READY,
        CE_ERR_POP_EMPTY,
        CE_ERR_DP_OVERFLOW
    } ce_err_t;

endpackage

// File: rtl/pairhmm_compute_engine_front_if.sv
// Worker-core <-> compute-engine request/result handshake bundle.
// Pure wiring; timing and backpressure are owned by the engine (slave) side.
interface pairhmm_compute_engine_front_if
    import PairHMMPackage::*;
();
    request_t request;
    logic     request_valid;
    logic     compute_engine_ready;
    result_t  result;
    logic     result_valid;
    logic     read_result;

    modport master (
        output request, request_valid, read_result,
        input  compute_engine_ready, result, result_valid
    );

    modport slave (
        input  request, request_valid, read_result,
        output compute_engine_ready, result, result_valid
    );
endinterface

// File: rtl/pairhmm_result_fifo.sv
// Generic synchronous first-word-fall-through FIFO with occupancy count.
// Head visible the cycle after a write into empty; writes when full and reads when empty are ignored.
module pairhmm_result_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 8
) (
    input  logic                       core_clk,
    input  logic                       arst_n,
    input  logic                       wr_vld,
    input  T                           wr_dat,
    input  logic                       rd_rdy,
    output T                           rd_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    T                mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign rd_dat = mem_q[rd_ptr_q];
    assign push   = wr_vld & ~full;
    assign pop    = rd_rdy & ~empty;

    // Power-of-two depth lets the pointers wrap by plain overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge core_clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_dat;
    end
endmodule

// File: rtl/pairhmm_compute_engine_front.sv
// Credit-gated request front end for the PairHMM datapath with FWFT result buffer; perf counters under PHMM_CE_PERF_CNT_EN.
// Request reaches datapath 1 cycle after accept; ready drops once FIFO_DEPTH requests are unpopped.
module pairhmm_compute_engine_front
    import PairHMMPackage::*;
#(
    parameter int FIFO_DEPTH = CE_FIFO_DEPTH_DEFAULT,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clock_i,
    input  logic                          reset_n_i,
    pairhmm_compute_engine_front_if.slave wk,
    output request_t                      dp_request_o,
    output logic                          dp_valid_o,
    input  result_t                       dp_result_i,
    input  logic                          dp_result_valid_i,
    output logic                          err_o,
    output logic [CNT_WIDTH-1:0]          perf_req_cnt_o,
    output logic [CNT_WIDTH-1:0]          perf_stall_cnt_o
);
    localparam int OW = $clog2(FIFO_DEPTH+1);

    logic [OW-1:0] outstanding_q, outstanding_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          dp_valid_q, dp_valid_d;
    request_t      dp_request_q, dp_request_d;
    ce_err_t       err_cause_q, err_cause_d;

    logic          fifo_full, fifo_empty;
    logic [OW-1:0] fifo_count;
    result_t       fifo_head;
    logic          accept, stall, pop, pop_empty, dp_drop, fifo_wr;

    assign accept    = wk.request_valid & ready_q;
    assign stall     = wk.request_valid & ~ready_q;
    assign pop       = wk.read_result & ~fifo_empty;
    assign pop_empty = wk.read_result & fifo_empty;
    // Nothing owed by the datapath when outstanding is 0, so any result then is stale
    assign dp_drop   = dp_result_valid_i & (fifo_full | (outstanding_q == '0));
    assign fifo_wr   = dp_result_valid_i & ~dp_drop;

    pairhmm_result_fifo #(
        .T     (result_t),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .core_clk (clock_i),
        .arst_n   (reset_n_i),
        .wr_vld   (fifo_wr),
        .wr_dat   (dp_result_i),
        .rd_rdy   (wk.read_result),
        .rd_dat   (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        outstanding_d = outstanding_q;
        case ({accept, pop})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase
        // Registered ready keeps the worker free of any input-to-ready path
        ready_d      = (outstanding_d < OW'(FIFO_DEPTH));
        dp_valid_d   = accept;
        dp_request_d = accept ? wk.request : '0;
        err_d        = err_q | stall | pop_empty | dp_drop;
        err_cause_d  = err_cause_q;
        if (err_cause_q == CE_ERR_NONE) begin
            if (stall)          err_cause_d = CE_ERR_REQ_NOT_READY;
            else if (pop_empty) err_cause_d = CE_ERR_POP_EMPTY;
            else if (dp_drop)   err_cause_d = CE_ERR_DP_OVERFLOW;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            outstanding_q <= '0;
            ready_q       <= 1'b0;
            err_q         <= 1'b0;
            dp_valid_q    <= 1'b0;
            dp_request_q  <= '0;
            err_cause_q   <= CE_ERR_NONE;
        end else begin
            outstanding_q <= outstanding_d;
            ready_q       <= ready_d;
            err_q         <= err_d;
            dp_valid_q    <= dp_valid_d;
            dp_request_q  <= dp_request_d;
            err_cause_q   <= err_cause_d;
        end
    end

    assign wk.compute_engine_ready = ready_q;
    assign wk.result_valid         = ~fifo_empty;
    assign wk.result               = fifo_empty ? '0 : fifo_head;
    assign dp_request_o            = dp_request_q;
    assign dp_valid_o              = dp_valid_q;
    assign err_o                   = err_q;

    a_occupancy_within_credit: assert property (
        @(posedge clock_i) disable iff (!reset_n_i) fifo_count <= outstanding_q);

`ifdef PHMM_CE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] req_cnt_q, req_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        req_cnt_d   = req_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept && !(&req_cnt_q))  req_cnt_d   = req_cnt_q + CNT_WIDTH'(1);
        if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            req_cnt_q   <= req_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_req_cnt_o   = req_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`else
    assign perf_req_cnt_o   = '0;
    assign perf_stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pairhmm_compute_engine_front.sv
// Randomized bench for pairhmm_compute_engine_front against a queue-based model, FIFO_DEPTH=4.
module tb_pairhmm_compute_engine_front;
    import PairHMMPackage::*;

    localparam int DEPTH = 4;
    localparam int CNTW  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pairhmm_compute_engine_front_if wk();
    request_t          dp_req;
    logic              dp_vld;
    result_t           dp_res;
    logic              dp_res_vld;
    logic              err;
    logic [CNTW-1:0]   perf_req, perf_stall;

    pairhmm_compute_engine_front #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(CNTW)) dut (
        .clock_i           (clk),
        .reset_n_i         (rst_n),
        .wk                (wk.slave),
        .dp_request_o      (dp_req),
        .dp_valid_o        (dp_vld),
        .dp_result_i       (dp_res),
        .dp_result_valid_i (dp_res_vld),
        .err_o             (err),
        .perf_req_cnt_o    (perf_req),
        .perf_stall_cnt_o  (perf_stall)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Datapath behaviour the bench emulates: tag echoed, lengths packed into the score
    function automatic result_t dp_func(input request_t r);
        result_t x;
        x.tag            = r.tag;
        x.log_likelihood = {r.read_len, r.hap_len, 8'hA5};
        return x;
    endfunction

    // ---------------- behavioural model ----------------
    result_t     m_fifo[$];
    int          m_out;
    bit          m_ready, m_err, m_dpv;
    request_t    m_dpr;
    int unsigned m_req_cnt, m_stall_cnt;
    bit          a_acc, a_stl, a_pop, a_pe, a_bad;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            m_out = 0; m_ready = 0; m_err = 0; m_dpv = 0; m_dpr = '0;
            m_req_cnt = 0; m_stall_cnt = 0;
        end else begin
            a_acc = wk.request_valid && m_ready;
            a_stl = wk.request_valid && !m_ready;
            a_pop = wk.read_result && (m_fifo.size() != 0);
            a_pe  = wk.read_result && (m_fifo.size() == 0);
            a_bad = dp_res_vld && ((m_fifo.size() == DEPTH) || (m_out == 0));
            m_dpv = a_acc;
            m_dpr = a_acc ? wk.request : '0;
            if (a_pop) void'(m_fifo.pop_front());
            if (dp_res_vld && !a_bad) m_fifo.push_back(dp_res);
            m_out = m_out + int'(a_acc) - int'(a_pop);
            if (a_stl || a_pe || a_bad) m_err = 1;
            if (a_acc) m_req_cnt++;
            if (a_stl) m_stall_cnt++;
            m_ready = (m_out < DEPTH);
        end
    end

    result_t         c_res;
    logic [CNTW-1:0] c_req, c_stall;
    always @(negedge clk) begin
        c_res = (m_fifo.size() != 0) ? m_fifo[0] : '0;
`ifdef PHMM_CE_PERF_CNT_EN
        c_req   = CNTW'(m_req_cnt);
        c_stall = CNTW'(m_stall_cnt);
`else
        c_req   = '0;
        c_stall = '0;
`endif
        chk("cmp_ready",        wk.compute_engine_ready, m_ready);
        chk("cmp_result_valid", wk.result_valid, m_fifo.size() != 0);
        chk("cmp_result",       wk.result, c_res);
        chk("cmp_dp_valid",     dp_vld, m_dpv);
        chk("cmp_dp_request",   dp_req, m_dpr);
        chk("cmp_err",          err, m_err);
        chk("cmp_perf_req",     perf_req, c_req);
        chk("cmp_perf_stall",   perf_stall, c_stall);
    end

    // ---------------- datapath emulator ----------------
    typedef struct { int due; result_t r; } pend_t;
    pend_t pq[$];
    pend_t pe_item;
    int    cyc = 0;
    int    last_due = 0;
    int    dp_lat_fixed = 9;
    int    stray_cyc = -1;
    int    dp_due;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #1;
        dp_res_vld = 1'b0;
        dp_res     = '0;
        if (!rst_n) begin
            pq.delete();
            last_due = 0;
        end else begin
            if (cyc == stray_cyc) begin
                dp_res_vld = 1'b1;
                dp_res     = 40'hEE_DEAD_BEEF;
            end else if (pq.size() != 0 && pq[0].due <= cyc) begin
                pe_item    = pq.pop_front();
                dp_res_vld = 1'b1;
                dp_res     = pe_item.r;
            end
            if (dp_vld) begin
                dp_due = cyc + ((dp_lat_fixed > 0) ? dp_lat_fixed : int'($urandom_range(1, 15)));
                if (dp_due <= last_due) dp_due = last_due + 1;
                last_due   = dp_due;
                pe_item.due = dp_due;
                pe_item.r   = dp_func(dp_req);
                pq.push_back(pe_item);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        wk.request_valid = 1'b0;
        wk.read_result   = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_ready_low", wk.compute_engine_ready, 1'b0);
        tick();
        chk("rst_ready_up", wk.compute_engine_ready, 1'b1);
    endtask

    task automatic pop_expect(input result_t exp, input string name);
        int n = 0;
        while (!wk.result_valid && n < 60) begin
            tick();
            n++;
        end
        chk({name, "_avail"}, wk.result_valid, 1'b1);
        chk(name, wk.result, exp);
        wk.read_result = 1'b1;
        tick();
        wk.read_result = 1'b0;
    endtask

    request_t r0;
    request_t r3[5];
    request_t wr[20];
    int       issued, popped, n;

    initial begin
        wk.request = '0; wk.request_valid = 1'b0; wk.read_result = 1'b0;
        #2;
        chk("reset_ready",   wk.compute_engine_ready, 1'b0);
        chk("reset_rvalid",  wk.result_valid, 1'b0);
        chk("reset_dpvalid", dp_vld, 1'b0);
        chk("reset_err",     err, 1'b0);
        do_reset();

        // Single request, fixed latency
        dp_lat_fixed = 9;
        r0 = '{tag: 8'h11, read_len: 12'h123, hap_len: 12'h456};
        wk.request = r0; wk.request_valid = 1'b1;
        tick();
        wk.request_valid = 1'b0;
        chk("t1_dp_valid", dp_vld, 1'b1);
        chk("t1_dp_req",   dp_req, 32'h1112_3456);
        tick();
        chk("t1_dp_valid_once", dp_vld, 1'b0);
        pop_expect(40'h11_1234_56A5, "t1_result");
        chk("t1_rvalid_after", wk.result_valid, 1'b0);
        chk("t1_ready_after",  wk.compute_engine_ready, 1'b1);
        chk("t1_err",          err, 1'b0);

        // Back-to-back until credits run out, then overlapping accept and pop
        dp_lat_fixed = 3;
        foreach (r3[i]) r3[i] = request_t'($urandom);
        for (int i = 0; i < 7; i++) begin
            wk.request = r3[(i < 4) ? i : 4];
            wk.request_valid = 1'b1;
            tick();
            if (i == 3) chk("t3_ready_drop", wk.compute_engine_ready, 1'b0);
        end
        wk.request_valid = 1'b0;
        chk("t3_err", err, 1'b1);
`ifdef PHMM_CE_PERF_CNT_EN
        chk("t3_stall_cnt", perf_stall, 3);
`else
        chk("t3_stall_cnt", perf_stall, 0);
`endif
        repeat (10) tick();
        chk("t3_ready_full", wk.compute_engine_ready, 1'b0);
        pop_expect(dp_func(r3[0]), "t3_pop0");
        chk("t3_ready_freed", wk.compute_engine_ready, 1'b1);
        wk.request = r3[4]; wk.request_valid = 1'b1;
        chk("t3_pop1", wk.result, dp_func(r3[1]));
        wk.read_result = 1'b1;
        tick();
        wk.request_valid = 1'b0; wk.read_result = 1'b0;
        chk("t3_ready_same", wk.compute_engine_ready, 1'b1);
        chk("t3_dp_valid",   dp_vld, 1'b1);
        pop_expect(dp_func(r3[2]), "t3_pop2");
        pop_expect(dp_func(r3[3]), "t3_pop3");
        pop_expect(dp_func(r3[4]), "t3_pop4");
        chk("t3_drained", wk.result_valid, 1'b0);

        // Wrap-around with random datapath latency and random pops
        do_reset();
        dp_lat_fixed = 0;
        foreach (wr[i]) wr[i] = request_t'($urandom);
        issued = 0; popped = 0; n = 0;
        while (popped < 20 && n < 3000) begin
            wk.request_valid = 1'b0;
            wk.read_result   = 1'b0;
            if (issued < 20 && wk.compute_engine_ready && $urandom_range(0, 3) != 0) begin
                wk.request = wr[issued];
                wk.request_valid = 1'b1;
                issued++;
            end
            if (wk.result_valid && $urandom_range(0, 2) != 0) begin
                chk("t4_order", wk.result, dp_func(wr[popped]));
                wk.read_result = 1'b1;
                popped++;
            end
            tick();
            n++;
        end
        wk.request_valid = 1'b0; wk.read_result = 1'b0;
        tick();
        chk("t4_popped", popped, 20);
        chk("t4_err",    err, 1'b0);
`ifdef PHMM_CE_PERF_CNT_EN
        chk("t4_req_cnt", perf_req, 20);
`else
        chk("t4_req_cnt", perf_req, 0);
`endif

        // Pop while empty
        wk.read_result = 1'b1;
        tick();
        wk.read_result = 1'b0;
        chk("t5_err",    err, 1'b1);
        chk("t5_rvalid", wk.result_valid, 1'b0);
        chk("t5_ready",  wk.compute_engine_ready, 1'b1);

        // Reset with results buffered, then a stray datapath result
        dp_lat_fixed = 2;
        for (int i = 0; i < 3; i++) begin
            wk.request = request_t'($urandom);
            wk.request_valid = 1'b1;
            tick();
        end
        wk.request_valid = 1'b0;
        repeat (12) tick();
        chk("t6_buffered", wk.result_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_ready0",  wk.compute_engine_ready, 1'b0);
        chk("t6_rvalid0", wk.result_valid, 1'b0);
        chk("t6_result0", wk.result, 40'h0);
        chk("t6_dpv0",    dp_vld, 1'b0);
        chk("t6_err0",    err, 1'b0);
        chk("t6_perf0",   perf_req, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        stray_cyc = cyc + 1;
        repeat (4) tick();
        chk("t6_stray_err",    err, 1'b1);
        chk("t6_stray_rvalid", wk.result_valid, 1'b0);
        chk("t6_stray_ready",  wk.compute_engine_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
